bitonic_sort_ctrl: RTL and testbench

- Iterative bitonic sort sequencer. A single shared layer of index/2 compare-exchange (max/min) lanes is reused across every pass of the bitonic network.
- Accepts one vector of `index` unsigned elements over a valid/ready handshake and steps through all L(L+1)/2 passes, where L = index_width, one pass per clock.
- Presents the ascending-sorted vector on a valid/ready output.
- Sits between the sample packer and downstream consumers. It is the area-reduced alternative to the fully unrolled stage pipeline.

---
 rtl/bitonic_sort_ctrl.sv | 142 ++++++++++++++
 tb/tb_bitonic_sort_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort_ctrl.sv
// Iterative bitonic sorter: one shared layer of index/2 compare-exchange lanes is reused for every network pass.
// Define BITONIC_DESC_EN to sort in descending order (element 0 largest); default build sorts ascending.
module bitonic_sort_ctrl #(
    parameter int width       = 8,
    parameter int index       = 8,
    parameter int index_width = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width*index-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [width*index-1:0]     out_data,
    output logic                       busy,
    output logic [2*index_width-1:0]   pass_idx
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never withdrawn by this block once raised, and data stays stable until the transfer.

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    localparam logic [index_width:0]     IDX_L  = (index_width+1)'(index);
    localparam logic [index_width:0]     ONE_L  = (index_width+1)'(1);
    localparam logic [index_width:0]     TWO_L  = (index_width+1)'(2);
    localparam logic [2*index_width-1:0] PONE_L = (2*index_width)'(1);

    state_t                   state_q;
    logic [width-1:0]         w_q [index];
    logic [width-1:0]         w_d [index];
    logic [width-1:0]         in_w [index];
    logic [index_width:0]     k_q, j_q;
    logic [2*index_width-1:0] pass_q;
    logic                     in_ready_q, out_valid_q, busy_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign pass_idx  = pass_q;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < index; i++) begin
            in_w[i]                    = in_data[i*width +: width];
            out_data[i*width +: width] = w_q[i];
        end
    end

    // One pass of the network for the current (k, j): lane i pairs with i^j when that partner is higher.
    always_comb begin
        logic [index_width:0] ii;
        logic [index_width:0] ll;
        logic                 up;
        logic [width-1:0]     lo;
        logic [width-1:0]     hi;
        ii  = '0;
        ll  = '0;
        up  = 1'b0;
        lo  = '0;
        hi  = '0;
        w_d = w_q;
        for (int i = 0; i < index; i++) begin
            ii = (index_width+1)'(i);
            ll = ii ^ j_q;
            up = ((ii & k_q) == '0);
`ifdef BITONIC_DESC_EN
            up = !up;
`endif
            if (ll > ii) begin
                lo = w_q[ii[index_width-1:0]];
                hi = w_q[ll[index_width-1:0]];
                if (up ? (lo > hi) : (lo < hi)) begin
                    w_d[ii[index_width-1:0]] = hi;
                    w_d[ll[index_width-1:0]] = lo;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < index; i++) w_q[i] <= '0;
            k_q         <= TWO_L;
            j_q         <= ONE_L;
            pass_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        w_q        <= in_w;
                        k_q        <= TWO_L;
                        j_q        <= ONE_L;
                        pass_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SORT;
                    end
                end
                SORT: begin
                    w_q <= w_d;
                    if (j_q > ONE_L) begin
                        j_q    <= j_q >> 1;
                        pass_q <= pass_q + PONE_L;
                    end else if (k_q < IDX_L) begin
                        k_q    <= k_q << 1;
                        j_q    <= k_q;
                        pass_q <= pass_q + PONE_L;
                    end else begin
                        pass_q      <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready stays low here so a vector offered alongside out_ready waits a cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        k_q         <= TWO_L;
                        j_q         <= ONE_L;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    pass_q      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl with hand-computed sorted vectors; honours BITONIC_DESC_EN.
module tb_bitonic_sort_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [5:0]  pass_idx;

    int vectors;
    int miscompares;

    bitonic_sort_ctrl #(.width(8), .index(8), .index_width(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .pass_idx  (pass_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Expected values are written ascending; the descending build expects the element order reversed.
    function automatic logic [63:0] ord(input logic [63:0] asc);
        logic [63:0] r;
        r = asc;
`ifdef BITONIC_DESC_EN
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = asc[(7-i)*8 +: 8];
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one vector, checks the six pass cycles, then checks the result on the completion edge.
    task automatic run_vec(input string tag, input logic [63:0] vin, input logic [63:0] vexp);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = vin;
        step();
        in_valid = 1'b0;
        for (int p = 0; p < 6; p++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_pass_idx"}, 64'(pass_idx), 64'(p));
            chk({tag, "_valid_early"}, 64'(out_valid), 64'd0);
            step();
        end
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_pass_done"}, 64'(pass_idx), 64'd0);
        chk({tag, "_data"}, out_data, vexp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pass_idx", 64'(pass_idx), 64'd0);
        chk("rst_data", out_data, 64'd0);
        rst = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        run_vec("reversed", pk(7, 6, 5, 4, 3, 2, 1, 0), ord(pk(0, 1, 2, 3, 4, 5, 6, 7)));
        step();
        chk("reversed_valid_drop", 64'(out_valid), 64'd0);
        chk("reversed_in_ready", 64'(in_ready), 64'd1);

        run_vec("ascending", pk(0, 1, 2, 3, 4, 5, 6, 7), ord(pk(0, 1, 2, 3, 4, 5, 6, 7)));
        step();

        run_vec("constant", {8{8'h55}}, {8{8'h55}});
        step();

        run_vec("extremes", pk(8'hFF, 8'h00, 8'h80, 8'h01, 8'hFE, 8'h7F, 8'h00, 8'hFF),
                ord(pk(8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'hFF)));
        step();

        // Backpressure with the next vector already offered.
        out_ready = 1'b0;
        run_vec("bp", pk(40, 10, 30, 20, 80, 60, 70, 50), ord(pk(10, 20, 30, 40, 50, 60, 70, 80)));
        in_valid = 1'b1;
        in_data  = pk(9, 200, 3, 3, 100, 0, 50, 1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", out_data, ord(pk(10, 20, 30, 40, 50, 60, 70, 80)));
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);
        step();
        in_valid = 1'b0;
        chk("bp_next_busy", 64'(busy), 64'd1);
        chk("bp_next_in_ready", 64'(in_ready), 64'd0);
        chk("bp_next_pass", 64'(pass_idx), 64'd0);
        for (int c = 0; c < 6; c++) step();
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_data", out_data, ord(pk(0, 1, 3, 3, 9, 50, 100, 200)));
        step();

        // Reset while pass 3 is executing.
        in_valid = 1'b1;
        in_data  = pk(5, 4, 3, 2, 1, 0, 7, 6);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("mid_pass3", 64'(pass_idx), 64'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pass", 64'(pass_idx), 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_no_output", 64'(out_valid), 64'd0);
        run_vec("after_rst", pk(3, 1, 2, 0, 7, 5, 6, 4), ord(pk(0, 1, 2, 3, 4, 5, 6, 7)));
        step();

        // Reset while holding a finished vector.
        out_ready = 1'b0;
        run_vec("done_rst", pk(1, 1, 0, 0, 2, 2, 3, 3), ord(pk(0, 0, 1, 1, 2, 2, 3, 3)));
        rst = 1'b0;
        #1;
        chk("done_rst_valid", 64'(out_valid), 64'd0);
        chk("done_rst_data", out_data, 64'd0);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("done_rst_in_ready", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
